// File: rtl/imem_loader.sv
// Instruction-memory program loader: assembles a big-endian byte stream into words
// and writes them from address 0 while holding the core. Optional IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
  // byte_ready depends only on state, never on byte_valid.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd3;
`endif

  localparam logic [ADDR_W:0] CAP      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ZERO_CNT = '0;
  localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]      state;
  logic [2:0]      state_nx;
  logic [ADDR_W:0] count;
  logic [ADDR_W:0] index;
  logic [ADDR_W:0] index_inc;
  logic [1:0]      byte_cnt;
  logic [31:0]     word;
  logic            accept;
  logic            clip;
  logic [ADDR_W:0] count_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      sum;
`endif

  assign accept    = byte_valid && byte_ready;
  assign index_inc = index + ONE_CNT;
  assign clip      = (word_count > CAP);
  assign count_in  = clip ? CAP : word_count;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state == S_LOAD) || (state == S_CHK);
`else
  assign byte_ready = (state == S_LOAD);
`endif
  assign imem_we    = (state == S_WRITE);
  assign imem_addr  = {{(29 - ADDR_W){1'b0}}, index, 2'b00};
  assign imem_wdata = word;
  assign cpu_hold   = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign dbg_state  = state;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (word_count == ZERO_CNT) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept && (byte_cnt == 2'd3)) begin
          state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        if (index_inc == count) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nx = S_CHK;
`else
          state_nx = S_DONE;
`endif
        end else begin
          state_nx = S_LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          state_nx = S_DONE;
        end
      end
`endif
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      index    <= '0;
      byte_cnt <= 2'd0;
      word     <= 32'd0;
      err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= 8'd0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            count    <= count_in;
            index    <= '0;
            byte_cnt <= 2'd0;
            word     <= 32'd0;
            err      <= clip;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= 8'd0;
`endif
          end
        end
        S_LOAD: begin
          // Shifting in from the bottom leaves byte 0 in [31:24] after four bytes.
          if (accept) begin
            word     <= {word[23:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum      <= sum + byte_in;
`endif
          end
        end
        S_WRITE: begin
          index <= index_inc;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept && (byte_in != sum)) begin
            err <= 1'b1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (ADDR_W=2 so clipping is reachable); follows
// IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;

  localparam int ADDR_W = 2;
  localparam int CAP    = 4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              imem_we;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // Clock and cycle stamp
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  int          wr_cyc_q[$];
  int          done_cyc_q[$];
  logic        done_err_q[$];
  int          hold_low_q[$];
  logic [7:0]  pay[$];
  logic [7:0]  exp_sum;
  logic        exp_err;
  int          exp_words;
  int          s_cyc;
  int          n_cmp  = 0;
  int          n_fail = 0;

  always @(negedge clk) begin : monitor
    logic [31:0] ea;
    logic [31:0] ed;
    if (imem_we === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", imem_addr, imem_wdata);
      end else begin
        ea = exp_addr_q.pop_front();
        ed = exp_q.pop_front();
        if (imem_addr !== ea || imem_wdata !== ed) begin
          n_fail++;
          $display("FAIL write: addr=%h data=%h, required addr=%h data=%h", imem_addr, imem_wdata, ea, ed);
        end
      end
    end
    if (done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_err_q.push_back(err);
    end
    if (cpu_hold !== 1'b1) hold_low_q.push_back(cyc);
  end

  // Reference model: words are byte groups of four, big-endian, at index*4
  task automatic model_load(input int n);
    exp_q.delete();
    exp_addr_q.delete();
    exp_words = (n > CAP) ? CAP : n;
    exp_err   = (n > CAP);
    exp_sum   = 8'd0;
    for (int i = 0; i < exp_words; i++) begin
      exp_addr_q.push_back(32'(i * 4));
      exp_q.push_back({pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]});
      for (int j = 0; j < 4; j++) exp_sum = exp_sum + pay[4*i+j];
    end
  endtask

  task automatic clear_obs();
    wr_cyc_q.delete();
    done_cyc_q.delete();
    done_err_q.delete();
    hold_low_q.delete();
  endtask

  task automatic fill_pay(input int nbytes);
    pay.delete();
    for (int i = 0; i < nbytes; i++) pay.push_back(8'($urandom));
  endtask

  // Drivers (all return at posedge+1)
  task automatic idle(input int g);
    byte_valid = 1'b0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (k < 50) begin
      @(negedge clk);
      if (byte_ready === 1'b1) break;
      k++;
    end
    if (k >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL byte_ready_timeout: byte_ready=%b, required 1 within 50 cycles", byte_ready);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_words(input int nw, input int gap_max);
    for (int i = 0; i < 4 * nw; i++) begin
      idle($urandom_range(0, gap_max));
      send_byte(pay[i]);
    end
  endtask

  task automatic send_chk(input bit bad);
    if (CHK_EN) send_byte(exp_sum + (bad ? 8'd1 : 8'd0));
  endtask

  task automatic do_start(input int n);
    word_count = (ADDR_W + 1)'(n);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_cyc_q.size() == 0 && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cyc_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: no done pulse, required one within 400 cycles");
      done_cyc_q.push_back(-1);
      done_err_q.push_back(1'bx);
    end
    @(posedge clk);
    #1;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({byte_ready, imem_we, cpu_hold, done, err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/we/hold/done/err=%b, required 00000",
               {byte_ready, imem_we, cpu_hold, done, err});
    end
    n_cmp++;
    if (imem_addr !== 32'd0 || imem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h, required 0/0", imem_addr, imem_wdata);
    end
    rst_n = 1'b1;
    idle(2);

    // Abort a word after two bytes; nothing may be written
    clear_obs();
    exp_q.delete();
    exp_addr_q.delete();
    fill_pay(4);
    do_start(1);
    send_byte(pay[0]);
    send_byte(pay[1]);
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({byte_ready, imem_we, cpu_hold, done, err} !== 5'b0 || imem_addr !== 32'd0 || imem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_midload: ready/we/hold/done/err=%b addr=%h wdata=%h, required all 0",
               {byte_ready, imem_we, cpu_hold, done, err}, imem_addr, imem_wdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    n_cmp++;
    if (wr_cyc_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_midload_writes: writes=%0d, required 0", wr_cyc_q.size());
    end

    clear_obs();
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    model_load(1);
    do_start(1);
    send_words(1, 0);
    send_chk(1'b0);
    wait_done();
    n_cmp++;
    if (wr_cyc_q.size() != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_reload: writes=%0d pending=%0d, required 1/0", wr_cyc_q.size(), exp_q.size());
    end
  endtask

  task automatic test_two_words();
    clear_obs();
    pay = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
    model_load(2);
    do_start(2);
    send_words(2, 0);
    send_chk(1'b0);
    wait_done();
    n_cmp++;
    if (wr_cyc_q.size() != 2 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL two_words_count: writes=%0d pending=%0d, required 2/0", wr_cyc_q.size(), exp_q.size());
    end else begin
      n_cmp++;
      if (wr_cyc_q[0] - s_cyc != 4 || wr_cyc_q[1] - wr_cyc_q[0] != 5) begin
        n_fail++;
        $display("FAIL two_words_timing: first=+%0d gap=%0d, required +4/5",
                 wr_cyc_q[0] - s_cyc, wr_cyc_q[1] - wr_cyc_q[0]);
      end
      n_cmp++;
      if (done_cyc_q[0] - wr_cyc_q[1] != (CHK_EN ? 2 : 1)) begin
        n_fail++;
        $display("FAIL two_words_done: done at write+%0d, required +%0d",
                 done_cyc_q[0] - wr_cyc_q[1], CHK_EN ? 2 : 1);
      end
    end
    n_cmp++;
    foreach (hold_low_q[i]) begin
      if (hold_low_q[i] >= s_cyc && hold_low_q[i] <= done_cyc_q[0]) begin
        n_fail++;
        $display("FAIL two_words_hold: cpu_hold=0 at cycle %0d, required 1 through done", hold_low_q[i]);
        break;
      end
    end
    n_cmp++;
    if (cpu_hold !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL two_words_end: hold/done/err=%b%b%b, required 000", cpu_hold, done, err);
    end
  endtask

  task automatic test_stall();
    clear_obs();
    pay = '{8'h20, 8'h08, 8'h00, 8'h05};
    model_load(1);
    do_start(1);
    send_byte(pay[0]);
    send_byte(pay[1]);
    idle(3);
    send_byte(pay[2]);
    send_byte(pay[3]);
    send_chk(1'b0);
    wait_done();
    n_cmp++;
    if (wr_cyc_q.size() != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_count: writes=%0d pending=%0d, required 1/0", wr_cyc_q.size(), exp_q.size());
    end else begin
      n_cmp++;
      if (wr_cyc_q[0] - s_cyc != 7) begin
        n_fail++;
        $display("FAIL stall_timing: write at start+%0d, required +7", wr_cyc_q[0] - s_cyc);
      end
    end
  endtask

  task automatic test_zero();
    clear_obs();
    model_load(0);
    do_start(0);
    wait_done();
    n_cmp++;
    if (done_cyc_q[0] != s_cyc || wr_cyc_q.size() != 0 || done_err_q[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_count: done at start+%0d writes=%0d err=%b, required +0/0/0",
               done_cyc_q[0] - s_cyc, wr_cyc_q.size(), done_err_q[0]);
    end
  endtask

  task automatic test_clip();
    clear_obs();
    fill_pay(16);
    model_load(5);
    do_start(5);
    send_words(2, 1);
    word_count = (ADDR_W + 1)'(1);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 8; i < 16; i++) send_byte(pay[i]);
    send_chk(1'b0);
    wait_done();
    n_cmp++;
    if (wr_cyc_q.size() != 4 || exp_q.size() != 0 || done_err_q[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL clip: writes=%0d pending=%0d err=%b, required 4/0/1",
               wr_cyc_q.size(), exp_q.size(), done_err_q[0]);
    end
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL clip_sticky: err=%b after done, required 1", err);
    end
    clear_obs();
    model_load(0);
    do_start(0);
    wait_done();
    n_cmp++;
    if (done_err_q[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b after new start, required 0", done_err_q[0]);
    end
  endtask

  task automatic test_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int r = 0; r < 2; r++) begin
      clear_obs();
      pay = '{8'h01, 8'h02, 8'h03, 8'h04};
      model_load(1);
      do_start(1);
      send_words(1, 0);
      send_byte(r == 0 ? 8'h0A : 8'h0B);
      wait_done();
      n_cmp++;
      if (wr_cyc_q.size() != 1 || exp_q.size() != 0 || done_err_q[0] !== 1'(r)) begin
        n_fail++;
        $display("FAIL checksum_%0d: writes=%0d pending=%0d err=%b, required 1/0/%0d",
                 r, wr_cyc_q.size(), exp_q.size(), done_err_q[0], r);
      end
    end
`else
    clear_obs();
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    model_load(1);
    do_start(1);
    send_words(1, 0);
    wait_done();
    n_cmp++;
    if (wr_cyc_q.size() != 1 || exp_q.size() != 0 || done_err_q[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL no_checksum: writes=%0d pending=%0d err=%b, required 1/0/0",
               wr_cyc_q.size(), exp_q.size(), done_err_q[0]);
    end
`endif
  endtask

  task automatic test_random();
    int  n;
    bit  bad;
    logic want_err;
    for (int it = 0; it < 10; it++) begin
      clear_obs();
      n   = $urandom_range(0, 7);
      bad = 1'($urandom_range(0, 1));
      fill_pay(4 * CAP);
      model_load(n);
      want_err = exp_err || (CHK_EN && exp_words > 0 && bad);
      do_start(n);
      send_words(exp_words, 2);
      if (exp_words > 0) send_chk(bad);
      wait_done();
      n_cmp++;
      if (wr_cyc_q.size() != exp_words || exp_q.size() != 0 || done_err_q[0] !== want_err) begin
        n_fail++;
        $display("FAIL random_%0d (n=%0d): writes=%0d pending=%0d err=%b, required %0d/0/%b",
                 it, n, wr_cyc_q.size(), exp_q.size(), done_err_q[0], exp_words, want_err);
      end
      idle($urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    test_reset();
    test_two_words();
    test_stall();
    test_zero();
    test_clip();
    test_checksum();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the single-cycle MIPS core. It is the write side of the instruction memory: the core's fetch path only reads instruction memory, and this block fills it. A byte stream is assembled into big-endian 32-bit words and written to consecutive word-aligned addresses from 0. The core is held off while loading is in progress.

## Interface
Parameters:
- `ADDR_W`, default 8: word-address width; capacity is 2^ADDR_W words.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle load request; sampled only in IDLE.
- `word_count`  in  ADDR_W+1  number of words to load; sampled with `start`.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe.
- `imem_addr`  out  32  byte address; always word-aligned, equal to word index × 4.
- `imem_wdata`  out  32  word being written.
- `cpu_hold`  out  1  core must not fetch or advance the PC.
- `done`  out  1  one-cycle pulse at the end of a load.
- `err`  out  1  sticky error flag; cleared by the next accepted `start`.

## Operation
- **IDLE**
  - `byte_ready`=0.
  - When `start`=1: latch `word_count` and clear the word index, byte counter and `err`.
  - If the latched count is 0, go to DONE; otherwise go to LOAD.
- **Count clipping:** if `word_count` > 2^ADDR_W, the count is clipped to 2^ADDR_W and `err` is set.
- **LOAD**
  - `byte_ready`=1.
  - A byte is accepted on each edge where `byte_valid`&&`byte_ready`.
  - Bytes are placed big-endian: byte 0 → [31:24], byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0].
  - After the 4th byte is accepted, go to WRITE.
- **WRITE** (exactly one cycle)
  - `imem_we`=1, `imem_addr`={index,2'b00} zero-extended to 32 bits, `imem_wdata`=assembled word.
  - `byte_ready`=0.
  - The index then increments.
  - If the index reaches the latched count, go to CHK when checksum is compiled in, otherwise DONE. If not, return to LOAD.
- **DONE** (one cycle): `done`=1, then go to IDLE.
- `cpu_hold`=1 in every state except IDLE.
- `start` is ignored outside IDLE.
- Index arithmetic is ADDR_W+1 bits wide, so a full 2^ADDR_W load does not wrap before the compare.
- The highest address written is (2^ADDR_W−1)×4.

## Timing
- **Reset values:** `byte_ready`, `imem_we`, `cpu_hold`, `done`, `err` = 0; `imem_addr`, `imem_wdata` = 0; state = IDLE.
- **Reset mid-load:** reset asserted in any state returns the block to IDLE immediately (asynchronous). The partial word is discarded and no write strobe is issued.
- **Stalls:** `byte_valid` low in LOAD stalls the block indefinitely with no timeout; the byte counter holds.
- **Word cost:** minimum 5 cycles per word (4 accept cycles + 1 write cycle). An N-word load takes at least 1+5N+1 cycles from `start` to the end of `done`.
- **start to LOAD:** `start` sampled at edge t → `cpu_hold`=1 and `byte_ready`=1 from t+1.
- **Write timing:** `imem_we` is high only in the cycle after the 4th byte is accepted. `imem_addr` and `imem_wdata` are stable during that cycle.
- **Write to done:** `done` goes high in the cycle after the last WRITE (or after CHK). `cpu_hold` falls in the same cycle that `done` falls.
- **Zero-count load:** `done` at t+1, no `imem_we`.

## Configuration
- **`IMEM_LOADER_CHECKSUM_EN` defined:**
  - The block keeps a running 8-bit sum (mod 256) of all payload bytes.
  - After the last WRITE it enters **CHK**, with `byte_ready`=1, and accepts one trailing byte.
  - If that byte ≠ the sum, `err` is set. The block then goes to DONE.
  - A zero-count load skips CHK.
- **`IMEM_LOADER_CHECKSUM_EN` not defined:**
  - No CHK state and no trailing byte.
  - `err` reports count clipping only.

## Test plan
- **Reset mid-load:** assert reset after 2 bytes of a word → outputs at reset values, no `imem_we`. Then a new load of 1 word 0xDEADBEEF writes 0xDEADBEEF to address 0.
- **Two words, continuous valid:** `word_count`=2, bytes 20 08 00 05 / 00 00 00 0C with `byte_valid` held high → `imem_we` at addr 0x0 with 0x20080005 and at addr 0x4 with 0x0000000C, 5 cycles apart. `done` 1 cycle after the second write. `cpu_hold` high from start+1 through `done`.
- **Stalled byte:** `byte_valid` dropped for 3 cycles between byte 1 and byte 2 → word still 0x20080005, with the write delayed by 3 cycles.
- **Zero count:** `word_count`=0 → `done` at start+1, no write, `err`=0.
- **Count clipping:** `ADDR_W`=2, `word_count`=5 → exactly 4 writes at 0x0, 0x4, 0x8, 0xC, `err`=1. A `start` issued mid-load is ignored.
- **Checksum (`IMEM_LOADER_CHECKSUM_EN`):** 1 word 01 02 03 04 + byte 0x0A → `err`=0. Repeated with trailing byte 0x0B → `err`=1. In both cases the word is written and `done` pulses.
